sd_dat_rx: RTL and testbench

SD_DAT_RX -- requirements
Module: sd_dat_rx

---
 rtl/sd_dat_rx_pkg.sv | 28 ++
 rtl/sd_dat_rx_crc.sv | 29 ++
 rtl/sd_dat_rx.sv | 158 +++++++++++++++
 tb/tb_sd_dat_rx.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sd_dat_rx_pkg.sv
// Shared definitions for the SD 4-bit DAT block receiver.
// Holds the field widths, the FSM state encodings, the CRC16-CCITT polynomial
// and a one-bit CRC step helper.
package sd_dat_rx_pkg;

  localparam int NIB_W  = 4;
  localparam int BYTE_W = 8;
  localparam int LEN_W  = 10;
  localparam int CRC_W  = 16;

  localparam logic [CRC_W-1:0] CRC_POLY = 16'h1021;

  localparam logic [2:0] ST_IDLE       = 3'd0;
  localparam logic [2:0] ST_WAIT_START = 3'd1;
  localparam logic [2:0] ST_DATA       = 3'd2;
  localparam logic [2:0] ST_CRC        = 3'd3;
  localparam logic [2:0] ST_END_BIT    = 3'd4;
  localparam logic [2:0] ST_DONE       = 3'd5;

  // Shift one serial bit into a CRC16 register, MSB-first feedback.
  function automatic logic [CRC_W-1:0] crc16_step(input logic [CRC_W-1:0] crc,
                                                  input logic              din);
    logic fb;
    fb = din ^ crc[CRC_W-1];
    crc16_step = {crc[CRC_W-2:0], 1'b0} ^ (fb ? CRC_POLY : '0);
  endfunction

endpackage

// File: rtl/sd_dat_rx_crc.sv
// One-line serial CRC16-CCITT accumulator (init 0).
// i_clr has priority over i_en; one bit is absorbed per enabled cycle.
module sd_crc16_bit
  import sd_dat_rx_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_clr,
  input  logic             i_en,
  input  logic             i_bit,
  output logic [CRC_W-1:0] o_crc
);

  logic [CRC_W-1:0] r_crc;

  // Clear on request, otherwise fold in one bit when enabled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_crc <= '0;
    end else if (i_clr) begin
      r_crc <= '0;
    end else if (i_en) begin
      r_crc <= crc16_step(r_crc, i_bit);
    end
  end

  assign o_crc = r_crc;

endmodule

// File: rtl/sd_dat_rx.sv
// SD 4-bit DAT block receiver.
// Waits for the start bit, assembles bytes from nibble pairs (high nibble
// first), runs one CRC16 per DAT line, checks the received CRCs and end bit,
// then pulses o_done with sticky status held until the next accepted arm.
module sd_dat_rx
  import sd_dat_rx_pkg::*;
#(
  parameter logic [15:0] TIMEOUT_CYCLES = 16'd1024
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_start_reading,
  input  logic [NIB_W-1:0]  i_sd_data,
  input  logic [LEN_W-1:0]  i_buf_len,
  output logic [BYTE_W-1:0] o_data,
  output logic              o_data_valid,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_crc_err,
  output logic              o_timeout
);

  logic [2:0]        r_state;
  logic [LEN_W-1:0]  r_len;
  logic [LEN_W-1:0]  r_byte_cnt;
  logic              r_nib_sel;
  logic [NIB_W-1:0]  r_hi_nib;
  logic [3:0]        r_bit_cnt;
  logic [15:0]       r_tmo_cnt;
  logic              r_err;
  logic [BYTE_W-1:0] r_data;
  logic              r_valid;
  logic              r_crc_err;
  logic              r_timeout;

  logic              w_arm;
  logic              w_last_byte;
  logic              w_crc_en;
  logic [NIB_W-1:0]  w_crc_mis;
  logic [CRC_W-1:0]  w_crc [NIB_W];

  // An arm is only honoured from IDLE and only with a non-zero length.
  assign w_arm       = (r_state == ST_IDLE) && i_start_reading && (i_buf_len != '0);
  assign w_last_byte = (r_byte_cnt == (r_len - LEN_W'(1)));
  assign w_crc_en    = (r_state == ST_DATA);

  genvar gi;
  generate
    for (gi = 0; gi < NIB_W; gi++) begin : g_crc
      sd_crc16_bit u_crc (
        .clk   (clk),
        .rst_n (rst_n),
        .i_clr (w_arm),
        .i_en  (w_crc_en),
        .i_bit (i_sd_data[gi]),
        .o_crc (w_crc[gi])
      );
    end
  endgenerate

  // Per-line compare of the received CRC bit against the computed CRC, MSB first.
  always_comb begin
    w_crc_mis = '0;
    for (int i = 0; i < NIB_W; i++) begin
      w_crc_mis[i] = i_sd_data[i] ^ w_crc[i][4'd15 - r_bit_cnt];
    end
  end

  // Block FSM with byte assembly, CRC/end-bit checking and status capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_len      <= '0;
      r_byte_cnt <= '0;
      r_nib_sel  <= 1'b0;
      r_hi_nib   <= '0;
      r_bit_cnt  <= '0;
      r_tmo_cnt  <= '0;
      r_err      <= 1'b0;
      r_data     <= '0;
      r_valid    <= 1'b0;
      r_crc_err  <= 1'b0;
      r_timeout  <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_arm) begin
            r_state    <= ST_WAIT_START;
            r_len      <= i_buf_len;
            r_byte_cnt <= '0;
            r_nib_sel  <= 1'b0;
            r_bit_cnt  <= '0;
            r_tmo_cnt  <= '0;
            r_err      <= 1'b0;
            r_crc_err  <= 1'b0;
            r_timeout  <= 1'b0;
          end
        end
        ST_WAIT_START: begin
          // The start-bit cycle itself carries no data and no CRC input.
          if (i_sd_data == '0) begin
            r_state <= ST_DATA;
          end else if (r_tmo_cnt == (TIMEOUT_CYCLES - 16'd1)) begin
            r_state   <= ST_DONE;
            r_timeout <= 1'b1;
          end else begin
            r_tmo_cnt <= r_tmo_cnt + 16'd1;
          end
        end
        ST_DATA: begin
          if (!r_nib_sel) begin
            r_hi_nib  <= i_sd_data;
            r_nib_sel <= 1'b1;
          end else begin
            r_nib_sel <= 1'b0;
            r_data    <= {r_hi_nib, i_sd_data};
            r_valid   <= 1'b1;
            // The last byte's strobe lands in the first CRC cycle.
            if (w_last_byte) begin
              r_state <= ST_CRC;
            end else begin
              r_byte_cnt <= r_byte_cnt + LEN_W'(1);
            end
          end
        end
        ST_CRC: begin
          if (w_crc_mis != '0) begin
            r_err <= 1'b1;
          end
          if (r_bit_cnt == 4'd15) begin
            r_state <= ST_END_BIT;
          end else begin
            r_bit_cnt <= r_bit_cnt + 4'd1;
          end
        end
        ST_END_BIT: begin
          r_state   <= ST_DONE;
          r_crc_err <= r_err | (i_sd_data != 4'hF);
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign o_data       = r_data;
  assign o_data_valid = r_valid;
  assign o_busy       = (r_state != ST_IDLE);
  assign o_done       = (r_state == ST_DONE);
  assign o_crc_err    = r_crc_err;
  assign o_timeout    = r_timeout;

endmodule

// File: tb/tb_sd_dat_rx.sv
// Directed bench for sd_dat_rx: a vector table of complete blocks plus
// hand-written sequences for reset, zero-length arm and start-bit timeout.
module tb_sd_dat_rx;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       i_start_reading = 1'b0;
  logic [3:0] i_sd_data = 4'hF;
  logic [9:0] i_buf_len = 10'd0;
  logic [7:0] o_data;
  logic       o_data_valid;
  logic       o_busy;
  logic       o_done;
  logic       o_crc_err;
  logic       o_timeout;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;

  sd_dat_rx #(.TIMEOUT_CYCLES(16'd16)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .i_start_reading (i_start_reading),
    .i_sd_data       (i_sd_data),
    .i_buf_len       (i_buf_len),
    .o_data          (o_data),
    .o_data_valid    (o_data_valid),
    .o_busy          (o_busy),
    .o_done          (o_done),
    .o_crc_err       (o_crc_err),
    .o_timeout       (o_timeout)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: record every strobe and every done pulse, sampled on the falling edge.
  logic [7:0] sb_data[$];
  int         sb_cyc[$];
  int         done_total = 0;
  int         done_cyc = 0;
  logic       last_err = 1'b0;
  logic       last_tmo = 1'b0;

  always @(negedge clk) begin
    if (o_data_valid) begin
      sb_data.push_back(o_data);
      sb_cyc.push_back(cyc);
    end
    if (o_done) begin
      done_total <= done_total + 1;
      done_cyc   <= cyc;
      last_err   <= o_crc_err;
      last_tmo   <= o_timeout;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  function automatic logic [15:0] crc_step(input logic [15:0] c, input logic b);
    logic fb;
    fb = b ^ c[15];
    crc_step = {c[14:0], 1'b0};
    if (fb) crc_step = crc_step ^ 16'h1021;
  endfunction

  typedef struct {
    int         len;
    logic [7:0] b0;
    int         fl;
    int         fb;
    logic [3:0] endn;
    int         wt;
    int         mid;
    logic       exp_err;
  } vec_t;

  vec_t vecs[7];

  task automatic wait_done(input int d0, input int limit);
    int t;
    t = 0;
    while (done_total == d0 && t < limit) begin
      @(negedge clk);
      #1;
      t++;
    end
  endtask

  task automatic run_block(input vec_t v, input int idx);
    logic [15:0] crc[4];
    logic [7:0]  b;
    logic [3:0]  nib;
    int sb0, d0, crc_cyc, mism, badsp, ns;
    sb0 = sb_data.size();
    d0  = done_total;
    for (int l = 0; l < 4; l++) crc[l] = 16'h0000;
    @(negedge clk);
    i_buf_len = v.len[9:0];
    i_start_reading = 1'b1;
    i_sd_data = 4'hF;
    @(negedge clk);
    i_start_reading = 1'b0;
    i_buf_len = 10'd0;
    repeat (v.wt) @(negedge clk);
    i_sd_data = 4'h0;
    @(negedge clk);
    for (int k = 0; k < v.len; k++) begin
      b = v.b0 + k[7:0];
      if (k == v.mid) begin
        i_start_reading = 1'b1;
        i_buf_len = 10'd2;
      end
      for (int h = 0; h < 2; h++) begin
        nib = (h == 0) ? b[7:4] : b[3:0];
        i_sd_data = nib;
        for (int l = 0; l < 4; l++) crc[l] = crc_step(crc[l], nib[l]);
        @(negedge clk);
        i_start_reading = 1'b0;
        i_buf_len = 10'd0;
      end
      if (k == v.mid) chk($sformatf("v%0d busy_after_mid_arm", idx), o_busy, 1);
    end
    crc_cyc = cyc;
    for (int k = 0; k < 16; k++) begin
      for (int l = 0; l < 4; l++) nib[l] = crc[l][15-k] ^ ((l == v.fl) && ((15 - k) == v.fb));
      i_sd_data = nib;
      @(negedge clk);
    end
    i_sd_data = v.endn;
    @(negedge clk);
    i_sd_data = 4'hF;
    wait_done(d0, 8);
    ns = sb_data.size() - sb0;
    chk($sformatf("v%0d strobe_count", idx), ns, v.len);
    mism = 0;
    badsp = 0;
    for (int k = 0; k < ns; k++) begin
      if (sb_data[sb0+k] !== (v.b0 + k[7:0])) mism++;
      if (k > 0 && (sb_cyc[sb0+k] - sb_cyc[sb0+k-1]) != 2) badsp++;
    end
    chk($sformatf("v%0d byte_mismatches", idx), mism, 0);
    chk($sformatf("v%0d strobe_spacing_errors", idx), badsp, 0);
    if (ns > 0) chk($sformatf("v%0d last_strobe_cycle", idx), sb_cyc[sb0+ns-1], crc_cyc);
    chk($sformatf("v%0d done_count", idx), done_total - d0, 1);
    chk($sformatf("v%0d crc_err_at_done", idx), last_err, v.exp_err);
    chk($sformatf("v%0d timeout_at_done", idx), last_tmo, 0);
    chk($sformatf("v%0d busy_after", idx), o_busy, 0);
    chk($sformatf("v%0d crc_err_held", idx), o_crc_err, v.exp_err);
  endtask

  initial begin
    int sb0, d0, arm_cyc;
    logic [7:0] b;

    vecs[0] = '{len: 1,    b0: 8'h00, fl: -1, fb: 0,  endn: 4'hF, wt: 2,  mid: -1, exp_err: 1'b0};
    vecs[1] = '{len: 1,    b0: 8'h00, fl: 2,  fb: 5,  endn: 4'hF, wt: 0,  mid: -1, exp_err: 1'b1};
    vecs[2] = '{len: 8,    b0: 8'hF0, fl: -1, fb: 0,  endn: 4'hF, wt: 3,  mid: -1, exp_err: 1'b0};
    vecs[3] = '{len: 3,    b0: 8'hA5, fl: -1, fb: 0,  endn: 4'hE, wt: 15, mid: -1, exp_err: 1'b1};
    vecs[4] = '{len: 4,    b0: 8'h3C, fl: 0,  fb: 15, endn: 4'hF, wt: 1,  mid: -1, exp_err: 1'b1};
    vecs[5] = '{len: 1023, b0: 8'h00, fl: -1, fb: 0,  endn: 4'hF, wt: 0,  mid: -1, exp_err: 1'b0};
    vecs[6] = '{len: 8,    b0: 8'h10, fl: -1, fb: 0,  endn: 4'hF, wt: 1,  mid: 4,  exp_err: 1'b0};

    // Reset state.
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_outputs", {o_data, o_data_valid, o_busy, o_done, o_crc_err, o_timeout}, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("no_done_after_reset", done_total, 0);

    // Zero-length arm must be ignored.
    i_start_reading = 1'b1;
    i_buf_len = 10'd0;
    @(negedge clk);
    i_start_reading = 1'b0;
    chk("len0_arm_busy", o_busy, 0);
    @(negedge clk);
    chk("len0_arm_busy_later", o_busy, 0);

    // Start-bit timeout with DAT held high.
    sb0 = sb_data.size();
    d0 = done_total;
    i_sd_data = 4'hF;
    i_buf_len = 10'd4;
    i_start_reading = 1'b1;
    @(posedge clk);
    #1 arm_cyc = cyc;
    @(negedge clk);
    i_start_reading = 1'b0;
    i_buf_len = 10'd0;
    wait_done(d0, 30);
    chk("tmo_done_count", done_total - d0, 1);
    chk("tmo_latency", done_cyc - arm_cyc, 16);
    chk("tmo_flag", last_tmo, 1);
    chk("tmo_crc_err", last_err, 0);
    chk("tmo_no_strobes", sb_data.size() - sb0, 0);
    chk("tmo_flag_held", o_timeout, 1);

    // Reset in the middle of a len=8 block, right as the 3rd byte strobes.
    sb0 = sb_data.size();
    d0 = done_total;
    @(negedge clk);
    i_buf_len = 10'd8;
    i_start_reading = 1'b1;
    @(negedge clk);
    i_start_reading = 1'b0;
    i_sd_data = 4'h0;
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      b = 8'h20 + k[7:0];
      i_sd_data = b[7:4];
      @(negedge clk);
      i_sd_data = b[3:0];
      @(negedge clk);
    end
    i_sd_data = 4'h2;
    rst_n = 1'b0;
    #1;
    chk("midrst_outputs", {o_data, o_data_valid, o_busy, o_done, o_crc_err, o_timeout}, 0);
    for (int k = 0; k < 34; k++) begin
      @(negedge clk);
      if (k == 2) rst_n = 1'b1;
      i_sd_data = k[3:0];
    end
    i_sd_data = 4'hF;
    repeat (6) @(negedge clk);
    #1;
    chk("midrst_strobes", sb_data.size() - sb0, 3);
    chk("midrst_no_done", done_total - d0, 0);
    chk("midrst_busy", o_busy, 0);

    // Table of complete blocks, including a fresh block after the reset.
    for (int i = 0; i < 7; i++) run_block(vecs[i], i);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
